// File: rtl/projectile_pool_if.sv
// Bus between the ship/enemy movers, the projectile pool and the VGA draw FSM.
// Enemy position and hit report exist only when HIT_DETECT_EN is defined.
interface projectile_pool_if #(
    parameter int NUM_SLOTS = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
);
    logic                     fire;
    logic [X_W-1:0]           ship_x;
    logic [NUM_SLOTS-1:0]     bullet_active;
    logic [NUM_SLOTS*X_W-1:0] bullet_x;
    logic [NUM_SLOTS*Y_W-1:0] bullet_y;
    logic                     fire_ack;
    logic                     fire_drop;
    logic                     cooldown_busy;
`ifdef HIT_DETECT_EN
    logic [X_W-1:0]           enemy_x;
    logic [Y_W-1:0]           enemy_y;
    logic                     hit;
    logic [2:0]               hit_slot;

    modport master (
        output fire, ship_x, enemy_x, enemy_y,
        input  bullet_active, bullet_x, bullet_y,
        input  fire_ack, fire_drop, cooldown_busy,
        input  hit, hit_slot
    );

    modport slave (
        input  fire, ship_x, enemy_x, enemy_y,
        output bullet_active, bullet_x, bullet_y,
        output fire_ack, fire_drop, cooldown_busy,
        output hit, hit_slot
    );
`else
    modport master (
        output fire, ship_x,
        input  bullet_active, bullet_x, bullet_y,
        input  fire_ack, fire_drop, cooldown_busy
    );

    modport slave (
        input  fire, ship_x,
        output bullet_active, bullet_x, bullet_y,
        output fire_ack, fire_drop, cooldown_busy
    );
`endif
endinterface

// File: rtl/projectile_pool.sv
// Multi-slot projectile manager: NUM_SLOTS bullets, fire cooldown, screen retirement.
// Optional enemy hit detection is enabled by defining HIT_DETECT_EN.
module projectile_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int Y_MAX     = 119,
    parameter int Y_STEP    = 1,
    parameter int COOLDOWN  = 3,
    parameter int ENEMY_W   = 8,
    parameter int ENEMY_H   = 4
) (
    input logic                movement_handler_clock,
    input logic                reset,
    projectile_pool_if.slave   bus
);

    localparam int YN = Y_W + 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [NUM_SLOTS-1:0] act_q;
    logic [NUM_SLOTS-1:0] act_d;
    logic [X_W-1:0]       x_q [NUM_SLOTS];
    logic [X_W-1:0]       x_d [NUM_SLOTS];
    logic [Y_W-1:0]       y_q [NUM_SLOTS];
    logic [Y_W-1:0]       y_d [NUM_SLOTS];
    logic [YN-1:0]        ny  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] coll;
    logic [CW-1:0]        cd_q;
    logic [CW-1:0]        cd_d;
    logic                 busy_q;
    logic                 ack_q;
    logic                 drop_q;
    logic                 accept;
    logic                 free_found;
    logic [2:0]           sel;
    logic                 hit_d;
    logic [2:0]           hslot_d;
    logic                 hit_q;
    logic [2:0]           hslot_q;

    // Next row for every slot, widened by one bit so the bound test never wraps.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ny[i] = {1'b0, y_q[i]} + YN'(Y_STEP);
        end
    end

`ifdef HIT_DETECT_EN
    // Per-slot hitbox test on pre-edge positions, done in 32 bits to avoid overflow.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            coll[i] = act_q[i]
                && (32'(x_q[i]) >= 32'(bus.enemy_x))
                && (32'(x_q[i]) <= 32'(bus.enemy_x) + 32'(ENEMY_W) - 32'd1)
                && (32'(y_q[i]) >= 32'(bus.enemy_y))
                && (32'(y_q[i]) <= 32'(bus.enemy_y) + 32'(ENEMY_H) - 32'd1);
        end
    end
`else
    logic unused_hitbox_cfg;

    // No enemy logic in this build: nothing ever collides.
    always_comb begin
        coll = '0;
    end

    assign unused_hitbox_cfg = ^{ENEMY_W[0], ENEMY_H[0]};
`endif

    // Lowest-index collision drives the hit report.
    always_comb begin
        hit_d   = 1'b0;
        hslot_d = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (coll[i] && !hit_d) begin
                hit_d   = 1'b1;
                hslot_d = 3'(i);
            end
        end
    end

    // Free-slot search, fire decision, per-slot movement and cooldown update.
    always_comb begin
        act_d      = act_q;
        x_d        = x_q;
        y_d        = y_q;
        cd_d       = cd_q;
        free_found = 1'b0;
        sel        = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!act_q[i] && !free_found) begin
                free_found = 1'b1;
                sel        = 3'(i);
            end
        end
        accept = bus.fire && (cd_q == '0) && free_found;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (act_q[i]) begin
                if (coll[i] || (ny[i] > YN'(Y_MAX))) begin
                    act_d[i] = 1'b0;
                    y_d[i]   = '0;
                end else begin
                    y_d[i] = ny[i][Y_W-1:0];
                end
            end else if (accept && (3'(i) == sel)) begin
                act_d[i] = 1'b1;
                x_d[i]   = bus.ship_x;
                y_d[i]   = '0;
            end
        end
        if (accept) begin
            cd_d = CW'(COOLDOWN);
        end else if (cd_q != '0) begin
            cd_d = cd_q - CW'(1);
        end
    end

    // State and registered status outputs; reset wins over everything.
    always_ff @(posedge movement_handler_clock) begin
        if (reset) begin
            act_q   <= '0;
            cd_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
            hit_q   <= 1'b0;
            hslot_q <= 3'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q   <= act_d;
            cd_q    <= cd_d;
            busy_q  <= (cd_d != '0);
            ack_q   <= accept;
            drop_q  <= bus.fire && !accept;
            hit_q   <= hit_d;
            hslot_q <= hslot_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign bus.bullet_x[g*X_W +: X_W] = x_q[g];
        assign bus.bullet_y[g*Y_W +: Y_W] = y_q[g];
    end

    assign bus.bullet_active = act_q;
    assign bus.fire_ack      = ack_q;
    assign bus.fire_drop     = drop_q;
    assign bus.cooldown_busy = busy_q;

`ifdef HIT_DETECT_EN
    assign bus.hit      = hit_q;
    assign bus.hit_slot = hslot_q;
`else
    logic unused_hit_state;

    assign unused_hit_state = ^{hit_q, hslot_q};
`endif

endmodule

// File: tb/tb_projectile_pool.sv
// Scoreboard bench for projectile_pool: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_projectile_pool;

    typedef struct {
        string      name;
        logic [3:0] act;
        int         s;
        logic [7:0] x;
        logic [6:0] y;
        logic       ack;
        logic       drop;
        logic       busy;
        logic       hit;
        logic [2:0] hs;
    } exp_t;

    logic movement_handler_clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t me;
    logic [7:0] got_x;
    logic [6:0] got_y;
    logic       bad;
    logic       got_hit;
    logic [2:0] got_hs;

    projectile_pool_if #(.NUM_SLOTS(4), .X_W(8), .Y_W(7)) bus ();

    projectile_pool dut (
        .movement_handler_clock (movement_handler_clock),
        .reset                  (reset),
        .bus                    (bus)
    );

    always #5 movement_handler_clock = ~movement_handler_clock;

    task automatic drive(input logic f, input logic [7:0] sx, input logic r);
        @(negedge movement_handler_clock);
        bus.fire   = f;
        bus.ship_x = sx;
        reset      = r;
        @(posedge movement_handler_clock);
        #1;
    endtask

    task automatic chk(input string n, input logic [3:0] a, input int s,
                       input logic [7:0] x, input logic [6:0] y,
                       input logic ack, input logic drop, input logic busy,
                       input logic hit = 1'b0, input logic [2:0] hs = 3'd0);
        exp_t e;
        e.name = n;
        e.act  = a;
        e.s    = s;
        e.x    = x;
        e.y    = y;
        e.ack  = ack;
        e.drop = drop;
        e.busy = busy;
        e.hit  = hit;
        e.hs   = hs;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge movement_handler_clock) begin
        if (q.size() > 0) begin
            me     = q.pop_front();
            checks = checks + 1;
            got_x  = bus.bullet_x[me.s*8 +: 8];
            got_y  = bus.bullet_y[me.s*7 +: 7];
`ifdef HIT_DETECT_EN
            got_hit = bus.hit;
            got_hs  = bus.hit_slot;
`else
            got_hit = me.hit;
            got_hs  = me.hs;
`endif
            bad = (bus.bullet_active !== me.act) || (got_x !== me.x)
               || (got_y !== me.y) || (bus.fire_ack !== me.ack)
               || (bus.fire_drop !== me.drop)
               || (bus.cooldown_busy !== me.busy)
               || (got_hit !== me.hit) || (got_hs !== me.hs);
            if (bad) begin
                errors = errors + 1;
                $display("FAIL %s: got act=%b x%0d=%0d y=%0d ack=%b drop=%b busy=%b hit=%b hs=%0d, want act=%b x=%0d y=%0d ack=%b drop=%b busy=%b hit=%b hs=%0d",
                         me.name, bus.bullet_active, me.s, got_x, got_y,
                         bus.fire_ack, bus.fire_drop, bus.cooldown_busy,
                         got_hit, got_hs, me.act, me.x, me.y, me.ack,
                         me.drop, me.busy, me.hit, me.hs);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fire   = 1'b0;
        bus.ship_x = 8'd0;
`ifdef HIT_DETECT_EN
        bus.enemy_x = 8'd200;
        bus.enemy_y = 7'd0;
`endif
        // Reset with fire held
        drive(1'b1, 8'd9, 1'b1);
        chk("reset1", 4'b0000, 0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd9, 1'b1);
        chk("reset2", 4'b0000, 0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // Single shot and advance
        drive(1'b1, 8'd50, 1'b0);
        chk("fire1", 4'b0001, 0, 8'd50, 7'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'd50, 1'b0);
        chk("adv1", 4'b0001, 0, 8'd50, 7'd1, 1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 8'd50, 1'b0);
        chk("adv5", 4'b0001, 0, 8'd50, 7'd5, 1'b0, 1'b0, 1'b0);

        // Fire held high: cooldown spacing then pool full
        drive(1'b0, 8'd0, 1'b1);
        for (int t = 1; t <= 17; t++) begin
            drive(1'b1, 8'(20 + t), 1'b0);
            case (t)
                1:  chk("hold_t1", 4'b0001, 0, 8'd21, 7'd0, 1'b1, 1'b0, 1'b1);
                2:  chk("hold_t2", 4'b0001, 0, 8'd21, 7'd1, 1'b0, 1'b1, 1'b1);
                4:  chk("hold_t4", 4'b0001, 0, 8'd21, 7'd3, 1'b0, 1'b1, 1'b0);
                5:  chk("hold_t5", 4'b0011, 1, 8'd25, 7'd0, 1'b1, 1'b0, 1'b1);
                9:  chk("hold_t9", 4'b0111, 2, 8'd29, 7'd0, 1'b1, 1'b0, 1'b1);
                13: chk("hold_t13", 4'b1111, 3, 8'd33, 7'd0, 1'b1, 1'b0, 1'b1);
                16: chk("hold_t16", 4'b1111, 3, 8'd33, 7'd3, 1'b0, 1'b1, 1'b0);
                17: chk("full_t17", 4'b1111, 0, 8'd21, 7'd16, 1'b0, 1'b1, 1'b0);
                default: ;
            endcase
        end

        // Reset with three bullets in flight and cooldown running
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd40, 1'b0);
        repeat (3) drive(1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'd41, 1'b0);
        repeat (3) drive(1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'd42, 1'b0);
        chk("three", 4'b0111, 2, 8'd42, 7'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'd0, 1'b1);
        chk("rst_flight", 4'b0000, 0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd77, 1'b0);
        chk("post_rst", 4'b0001, 0, 8'd77, 7'd0, 1'b1, 1'b0, 1'b1);

        // Top-of-screen retirement and same-edge fire
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd60, 1'b0);
        chk("fire60", 4'b0001, 0, 8'd60, 7'd0, 1'b1, 1'b0, 1'b1);
        repeat (119) drive(1'b0, 8'd0, 1'b0);
        chk("y119", 4'b0001, 0, 8'd60, 7'd119, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd70, 1'b0);
        chk("retire", 4'b0010, 0, 8'd60, 7'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        chk("slot1", 4'b0010, 1, 8'd70, 7'd1, 1'b0, 1'b0, 1'b1);

`ifdef HIT_DETECT_EN
        // Bullet entering the enemy box, then one just right of it
        drive(1'b0, 8'd0, 1'b1);
        bus.enemy_x = 8'd48;
        bus.enemy_y = 7'd10;
        drive(1'b1, 8'd50, 1'b0);
        repeat (10) drive(1'b0, 8'd0, 1'b0);
        chk("pre_hit", 4'b0001, 0, 8'd50, 7'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        chk("hit", 4'b0000, 0, 8'd50, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd56, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 1'b0);
        chk("miss56", 4'b0001, 0, 8'd56, 7'd11, 1'b0, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge movement_handler_clock);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
